// File: rtl/tt_um_sumador.sv
// Registered 4-bit ripple-carry adder with carry/overflow/zero flags and a sticky VALID bit.
// Optional subtract mode (uio_in[1]) is compiled in when SUMADOR_SUB_EN is defined.
module tt_um_sumador #(
    parameter int NBITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic             sub_mode;
    logic             unused_bits;
    logic [NBITS-1:0] op_a;
    logic [NBITS-1:0] op_b;
    logic [NBITS-1:0] b_eff;
    logic [NBITS-1:0] sum_w;
    logic [NBITS:0]   carry;

`ifdef SUMADOR_SUB_EN
    assign sub_mode    = uio_in[1];
    assign unused_bits = ^uio_in[7:2];
`else
    assign sub_mode    = 1'b0;
    assign unused_bits = ^uio_in[7:1];
`endif

    assign op_a = ui_in[NBITS-1:0];
    assign op_b = ui_in[NBITS+3:4];

    // Subtraction is A + ~B + 1: invert B and force the chain's carry-in high.
    assign b_eff    = sub_mode ? ~op_b : op_b;
    assign carry[0] = sub_mode ? 1'b1 : uio_in[0];

    generate
        for (genvar gi = 0; gi < NBITS; gi++) begin : g_fa
            assign sum_w[gi]   = op_a[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi+1] = (op_a[gi] & b_eff[gi]) | (carry[gi] & (op_a[gi] ^ b_eff[gi]));
        end
    endgenerate

    logic [NBITS-1:0] sum_reg,   sum_next;
    logic             cout_reg,  cout_next;
    logic             ovf_reg,   ovf_next;
    logic             zero_reg,  zero_next;
    logic             valid_reg, valid_next;

    always_comb begin
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;
        zero_next  = zero_reg;
        valid_next = valid_reg;
        if (ena) begin
            sum_next   = sum_w;
            cout_next  = carry[NBITS];
            ovf_next   = carry[NBITS-1] ^ carry[NBITS];
            zero_next  = (sum_w == '0);
            valid_next = 1'b1;
        end
    end

    // Reset wins over a same-edge capture, so operands present during reset are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
            zero_reg  <= zero_next;
            valid_reg <= valid_next;
        end
    end

    assign uo_out  = {valid_reg, zero_reg, ovf_reg, cout_reg, sum_reg};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_sumador.sv
// Scoreboard bench for tt_um_sumador: driver pushes model expectations, a monitor pops and compares.
module tb_tt_um_sumador;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;
    int txn = 0;

    logic [7:0] exp_q[$];
    logic [7:0] model_uo = 8'h00;

    tt_um_sumador #(.NBITS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic logic [7:0] model_result(input logic [7:0] ui, input logic [7:0] uio);
        int a, b, sa, sb, cin, full, sres, sum;
        bit sub, cout, ovf, zero;
        logic [7:0] r;
        a   = int'(ui[3:0]);
        b   = int'(ui[7:4]);
        cin = int'(uio[0]);
        sa  = (a >= 8) ? a - 16 : a;
        sb  = (b >= 8) ? b - 16 : b;
        sub = 1'b0;
`ifdef SUMADOR_SUB_EN
        sub = uio[1];
`endif
        if (sub) begin
            sum  = (a - b + 16) % 16;
            cout = (a >= b);
            sres = sa - sb;
        end else begin
            full = a + b + cin;
            sum  = full % 16;
            cout = (full >= 16);
            sres = sa + sb + cin;
        end
        ovf  = (sres > 7) || (sres < -8);
        zero = (sum == 0);
        r[3:0] = sum[3:0];
        r[4]   = cout;
        r[5]   = ovf;
        r[6]   = zero;
        r[7]   = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio);
        @(negedge clk);
        rst_n  = r;
        ena    = e;
        ui_in  = ui;
        uio_in = uio;
        if (!r)
            model_uo = 8'h00;
        else if (e)
            model_uo = model_result(ui, uio);
        exp_q.push_back(model_uo);
    endtask

    // Monitor: every edge with a pending transaction produces one registered result.
    always @(posedge clk) begin
        logic [7:0] exp_v;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            txn++;
            checks++;
            if (uo_out !== exp_v) begin
                errors++;
                $display("FAIL uo_out txn=%0d got=%02h expected=%02h", txn, uo_out, exp_v);
            end else begin
                $display("txn %0d ui_in=%02h uio_in=%02h uo_out=%02h ok", txn, ui_in, uio_in, uo_out);
            end
            checks++;
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                errors++;
                $display("FAIL uio_const txn=%0d got out=%02h oe=%02h expected 00/00", txn, uio_out, uio_oe);
            end
        end
    end

    initial begin
        logic [8:0] idx;
        logic [7:0] ui_v, uio_v;

        // Reset held two cycles with active-looking inputs.
        drive(1'b0, 1'b1, 8'hFF, 8'h01);
        drive(1'b0, 1'b1, 8'hFF, 8'h01);
        // Out of reset but not enabled: VALID must stay low.
        drive(1'b1, 1'b0, 8'h17, 8'h00);

        // Directed corners: overflow, wrap.
        drive(1'b1, 1'b1, 8'h17, 8'h00);
        drive(1'b1, 1'b1, 8'h1F, 8'h00);

        // Exhaustive add over A, B, CIN with ignored uio bits randomised.
        for (int i = 0; i < 512; i++) begin
            idx   = 9'(i);
            ui_v  = idx[7:0];
            uio_v = {6'($urandom), 1'b0, idx[8]};
            drive(1'b1, 1'b1, ui_v, uio_v);
        end

        // Hold: capture 3+4+1, then drop ena and change operands.
        drive(1'b1, 1'b1, 8'h43, 8'h01);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'hFF, 8'h01);

        // Mode-select bit: subtract when compiled in, ignored otherwise.
        drive(1'b1, 1'b1, 8'h53, 8'h02);

        // Reset on an enabled edge discards the operands.
        drive(1'b0, 1'b1, 8'h22, 8'h00);
        drive(1'b1, 1'b1, 8'h22, 8'h00);

        // Random mix of enable, reset and all input bits.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom));
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
